// File: rtl/mem_main_responder.sv
// Main-memory responder: serves whole-block reads after a fixed latency and
// single-word write-through writes, with same-edge write forwarding into captured blocks.
module mem_main_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 32,
    parameter int MEM_BYTES  = 4096,
    parameter int RD_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_rd_block_req,
    input  logic [ADDR_WIDTH-1:0]   mem_rd_block_base_addr,
    output logic                    mem_rd_block_ack,
    output logic [BLOCK_SIZE*8-1:0] mem_rd_block_data,
    input  logic                    mem_wr_bytes_req,
    input  logic [ADDR_WIDTH-1:0]   mem_wr_bytes_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wr_bytes_data,
    output logic                    mem_wr_bytes_ack,
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count
);

    localparam int WB    = DATA_WIDTH / 8;
    localparam int WPB   = BLOCK_SIZE / WB;
    localparam int MA_W  = $clog2(MEM_BYTES);
    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [MA_W-1:0] BLK_MASK = MA_W'(BLOCK_SIZE - 1);
    localparam logic [MA_W-1:0] WRD_MASK = MA_W'(WB - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [MA_W-1:0]         base_q, base_nxt;
    logic                    capture;
    logic [7:0]              mem [MEM_BYTES];
    logic [MA_W-1:0]         rd_idx, wr_idx;
    logic [BLOCK_SIZE*8-1:0] blk_merged;
    logic                    unused_addr;

    // Addresses wrap modulo MEM_BYTES; misaligned low bits are simply masked off.
    assign rd_idx      = mem_rd_block_base_addr[MA_W-1:0] & ~BLK_MASK;
    assign wr_idx      = mem_wr_bytes_addr[MA_W-1:0] & ~WRD_MASK;
    assign unused_addr = ^{mem_rd_block_base_addr, mem_wr_bytes_addr};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        base_nxt  = base_q;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_rd_block_req) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(RD_LATENCY - 1);
                    base_nxt  = rd_idx;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_rd_block_ack = (state == ACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
        base_q <= base_nxt;
    end

    // A write landing on the capture edge is merged so the block reflects it.
    always_comb begin
        blk_merged = '0;
        for (int j = 0; j < BLOCK_SIZE; j++)
            blk_merged[8*j +: 8] = mem[base_q + MA_W'(j)];
        for (int k = 0; k < WPB; k++)
            if (mem_wr_bytes_req && (wr_idx == base_q + MA_W'(k * WB)))
                blk_merged[k*DATA_WIDTH +: DATA_WIDTH] = mem_wr_bytes_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_block_data <= '0;
            rd_count          <= '0;
        end else begin
            if (capture)
                mem_rd_block_data <= blk_merged;
            if (state == ACK && rd_count != 16'hFFFF)
                rd_count <= rd_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_bytes_ack <= 1'b0;
            wr_count         <= '0;
        end else begin
            mem_wr_bytes_ack <= mem_wr_bytes_req;
            if (mem_wr_bytes_req && wr_count != 16'hFFFF)
                wr_count <= wr_count + 16'd1;
        end
    end

    // Array contents survive reset; only strobes outside reset commit.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr_bytes_req)
            for (int b = 0; b < WB; b++)
                mem[wr_idx + MA_W'(b)] <= mem_wr_bytes_data[8*b +: 8];
    end

endmodule

// File: tb/tb_mem_main_responder.sv
// Randomized and directed bench for mem_main_responder against a timestamp-based
// reference model of the memory array and read/write handshakes.
module tb_mem_main_responder;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req;
    logic [15:0]  rd_addr;
    logic         rd_ack;
    logic [255:0] rd_data;
    logic         wr_req;
    logic [15:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         wr_ack;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    always #5 clk = ~clk;

    mem_main_responder #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .BLOCK_SIZE(32),
        .MEM_BYTES(4096), .RD_LATENCY(L)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_rd_block_req(rd_req), .mem_rd_block_base_addr(rd_addr),
        .mem_rd_block_ack(rd_ack), .mem_rd_block_data(rd_data),
        .mem_wr_bytes_req(wr_req), .mem_wr_bytes_addr(wr_addr),
        .mem_wr_bytes_data(wr_data), .mem_wr_bytes_ack(wr_ack),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: byte array plus "ack due at cycle N" bookkeeping.
    bit   [7:0]   ref_mem [4096];
    int           cyc = 0;
    int           due = 0;
    int           base = 0;
    int           a;
    bit           busy = 0;
    bit           was_busy;
    logic         e_rd_ack = 0;
    logic         e_wr_ack = 0;
    logic [255:0] e_blk = '0;
    logic [15:0]  e_rc = '0;
    logic [15:0]  e_wc = '0;
    bit           chk_en = 1;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            busy = 0; e_rd_ack = 0; e_wr_ack = 0; e_blk = '0; e_rc = '0; e_wc = '0;
        end else begin
            was_busy = busy;
            if (e_rd_ack) begin
                if (e_rc != 16'hFFFF) e_rc++;
                busy = 0;
            end
            e_rd_ack = 0;
            e_wr_ack = wr_req;
            if (wr_req) begin
                a = int'(wr_addr) & ~3;
                for (int b = 0; b < 4; b++) ref_mem[(a + b) % 4096] = wr_data[8*b +: 8];
                if (e_wc != 16'hFFFF) e_wc++;
            end
            if (busy && cyc == due) begin
                for (int j = 0; j < 32; j++) e_blk[8*j +: 8] = ref_mem[(base + j) % 4096];
                e_rd_ack = 1;
            end
            if (!was_busy && rd_req) begin
                busy = 1;
                due  = cyc + L;
                base = int'(rd_addr) & ~31;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_ack", rd_ack, e_rd_ack);
            chk("wr_ack", wr_ack, e_wr_ack);
            chk("rd_data", rd_data, e_blk);
            chk("rd_count", rd_count, e_rc);
            chk("wr_count", wr_count, e_wc);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Holds req until ack, then steps past the ack cycle so the FSM is idle again.
    task automatic do_read(input logic [15:0] addr, output int n);
        rd_req  = 1'b1;
        rd_addr = addr;
        n = 0;
        do begin
            step();
            n++;
        end while (!rd_ack && n < 50);
        chk("rd_timeout", rd_ack, 1'b1);
        rd_req = 1'b0;
        step();
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_req = 1'b0;
        chk("wr_ack_pulse", wr_ack, 1'b1);
    endtask

    int n;

    initial begin
        rst = 1'b1; rd_req = 1'b1; rd_addr = 16'h0300;
        wr_req = 1'b1; wr_addr = 16'h0120; wr_data = 32'hFFFF_FFFF;
        repeat (3) step();
        chk("rst_rd_ack", rd_ack, 1'b0);
        chk("rst_wr_ack", wr_ack, 1'b0);
        chk("rst_data", rd_data, '0);
        chk("rst_counts", {rd_count, wr_count}, 32'h0);

        // Read held through reset release is accepted on the first edge out of reset.
        rst = 1'b0; wr_req = 1'b0;
        do_read(16'h0300, n);
        chk("lat_after_rst", n, L + 1);

        // Reset in the middle of a read aborts it; a held req restarts afterwards.
        rd_req = 1'b1; rd_addr = 16'h0040;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_no_ack", rd_ack, 1'b0);
        do_read(16'h0040, n);
        chk("lat_after_abort", n, L + 1);

        do_write(16'h0124, 32'hDEAD_BEEF);
        rd_req = 1'b1; rd_addr = 16'h0120;
        n = 0;
        do begin step(); n++; end while (!rd_ack && n < 50);
        chk("lat_0120", n, L + 1);
        chk("w1_0120", rd_data[63:32], 32'hDEAD_BEEF);
        chk("others_0120", rd_data & ~{192'h0, 32'hFFFF_FFFF, 32'h0}, '0);
        rd_req = 1'b0;
        step();
        chk("ack_one_wide", rd_ack, 1'b0);

        do_read(16'h0127, n);
        chk("w1_0127", rd_data[63:32], 32'hDEAD_BEEF);
        do_write(16'h0126, 32'hCAFE_F00D);
        do_read(16'h0120, n);
        chk("w1_misaligned", rd_data[63:32], 32'hCAFE_F00D);

        // Write on the capture edge is forwarded into the block.
        rd_req = 1'b1; rd_addr = 16'h0200;
        step();
        rd_req = 1'b0;
        repeat (L - 1) step();
        wr_req = 1'b1; wr_addr = 16'h0208; wr_data = 32'h1234_5678;
        step();
        wr_req = 1'b0;
        chk("fwd_ack", rd_ack, 1'b1);
        chk("fwd_w2", rd_data[95:64], 32'h1234_5678);
        step();

        // Write one edge after capture leaves the held block untouched.
        rd_req = 1'b1; rd_addr = 16'h0200;
        step();
        rd_req = 1'b0;
        repeat (L) step();
        chk("late_ack", rd_ack, 1'b1);
        wr_req = 1'b1; wr_addr = 16'h0208; wr_data = 32'h0BAD_F00D;
        step();
        wr_req = 1'b0;
        chk("late_w2", rd_data[95:64], 32'h1234_5678);
        step();

        do_write(16'h1004, 32'hA5A5_A5A5);
        do_read(16'h0000, n);
        chk("wrap_w1", rd_data[63:32], 32'hA5A5_A5A5);

        for (int i = 0; i < 400; i++) begin
            wr_req  = 1'($urandom_range(0, 1));
            wr_addr = 16'($urandom);
            wr_data = $urandom;
            if (rd_req) rd_addr = 16'($urandom);
            else if ($urandom_range(0, 3) == 0) begin
                rd_req  = 1'b1;
                rd_addr = 16'($urandom);
            end
            step();
            if (rd_req && rd_ack) rd_req = 1'b0;
        end
        wr_req = 1'b0;
        n = 0;
        while (rd_req && n < 50) begin
            step();
            n++;
            if (rd_ack) rd_req = 1'b0;
        end
        chk("rand_drain", rd_req, 1'b0);
        rd_req = 1'b0;
        repeat (3) step();

        chk_en = 0;
        wr_req = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            wr_addr = 16'($urandom);
            wr_data = $urandom;
            step();
        end
        wr_req = 1'b0;
        chk_en = 1;
        step(); step();
        chk("wr_sat", wr_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
